row_mem_responder: RTL and testbench



---
 rtl/row_mem_responder_if.sv | 47 ++++
 rtl/row_mem_responder.sv | 149 ++++++++++++++
 tb/tb_row_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/row_mem_responder_if.sv
// row_mem_responder_if: groups the LSU request/response channel, the host
// load port and the busy status of a PE row's memory responder.
// master = LSU/host side, slave = responder side.
interface row_mem_responder_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          busy;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output ld_valid,
        output ld_addr,
        output ld_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  ld_valid,
        input  ld_addr,
        input  ld_data,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output busy
    );
endinterface

// File: rtl/row_mem_responder.sv
// row_mem_responder: memory-side responder for a PE row's LSU.
// Requests are buffered in a 2-entry in-order queue and served one per cycle
// against a single-port local array; the host load port has priority.
// Optional feature: define ROW_MEM_WACK_EN to acknowledge every issued store
// with a one-cycle rsp_valid pulse carrying rsp_rdata = 0.
module row_mem_responder #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    row_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam int QD    = 2;

    // Queue bookkeeping
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic [1:0]    w_count_next;

    // Per-slot contents, gathered from the generate block below
    logic          w_q_we    [QD];
    logic [AW-1:0] w_q_addr  [QD];
    logic [DW-1:0] w_q_wdata [QD];

    // Queue head
    logic          w_head_we;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_wdata;

    // Array port
    logic          w_enq;
    logic          w_issue;
    logic          w_mem_we;
    logic          w_mem_re;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_mem_q;

    // Response pipeline
    logic          w_rsp_fire;
    logic          r_rsp_valid;
    logic          r_rsp_zero;

    // Ready only looks at the registered count, never at a same-cycle dequeue.
    assign bus.req_ready = (r_count != 2'd2);
    assign w_enq         = bus.req_valid & bus.req_ready;

    // Host writes own the single array port; the queue head waits.
    assign w_issue       = ~bus.ld_valid & (r_count != 2'd0);

    assign w_head_we     = w_q_we[r_rd_ptr];
    assign w_head_addr   = w_q_addr[r_rd_ptr];
    assign w_head_wdata  = w_q_wdata[r_rd_ptr];

    // Slot storage needs no reset: a slot is only read while counted valid.
    for (genvar gi = 0; gi < QD; gi++) begin : g_slot
        localparam logic SLOT = 1'(gi);
        logic          r_we;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_wdata;

        // Capture an accepted request into this slot when the write pointer selects it
        always_ff @(posedge clk) begin
            if (w_enq && (r_wr_ptr == SLOT)) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
        end

        assign w_q_we[gi]    = r_we;
        assign w_q_addr[gi]  = r_addr;
        assign w_q_wdata[gi] = r_wdata;
    end

    // Occupancy update from the enqueue/dequeue pair
    always_comb begin
        w_count_next = r_count;
        case ({w_enq, w_issue})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Queue pointers and count; reset flushes the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_count <= w_count_next;
            if (w_enq) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_issue) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Exactly one array operation per cycle: host write, store, or load
    assign w_mem_we    = bus.ld_valid | (w_issue & w_head_we);
    assign w_mem_re    = w_issue & ~w_head_we;
    assign w_mem_addr  = bus.ld_valid ? bus.ld_addr : w_head_addr;
    assign w_mem_wdata = bus.ld_valid ? bus.ld_data : w_head_wdata;

    // Single-port array with registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        if (w_mem_re) begin
            r_mem_q <= r_mem[w_mem_addr];
        end
    end

`ifdef ROW_MEM_WACK_EN
    // Every issued request completes with a response
    assign w_rsp_fire = w_issue;
`else
    // Only loads return a response
    assign w_rsp_fire = w_issue & ~w_head_we;
`endif

    // Response strobe, plus a flag that forces the data to zero for store
    // acks and after reset; the read register itself then simply holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_zero  <= 1'b1;
        end else begin
            r_rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_rsp_zero <= w_head_we;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_zero ? '0 : r_mem_q;
    assign bus.busy      = (r_count != 2'd0) | r_rsp_valid;

endmodule

// File: tb/tb_row_mem_responder.sv
// tb_row_mem_responder: directed scenarios plus randomized traffic, checked
// against a queue-level reference model of the responder.
module tb_row_mem_responder;
    localparam int DW = 32;
    localparam int AW = 8;

`ifdef ROW_MEM_WACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    row_mem_responder_if #(.DW(DW), .AW(AW)) bus_if ();

    row_mem_responder #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    // Reference model state: pending requests, array image, visible response
    req_t          m_q[$];
    logic [DW-1:0] m_mem [1 << AW];
    bit            m_rsp_valid = 1'b0;
    logic [DW-1:0] m_rsp_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Drive one cycle of stimulus and advance the model; returns at the
    // following falling edge with DUT outputs settled.
    task automatic cycle(input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit ldv,
                         input logic [AW-1:0] la, input logic [DW-1:0] ld);
        bit   acc;
        bit   iss;
        req_t h;
        req_t r;
        bus_if.req_valid = v;
        bus_if.req_we    = we;
        bus_if.req_addr  = a;
        bus_if.req_wdata = wd;
        bus_if.ld_valid  = ldv;
        bus_if.ld_addr   = la;
        bus_if.ld_data   = ld;
        acc = v && (m_q.size() < 2);
        iss = !ldv && (m_q.size() > 0);
        @(posedge clk);
        m_rsp_valid = 1'b0;
        if (ldv) m_mem[la] = ld;
        if (iss) begin
            h = m_q.pop_front();
            if (h.we) begin
                m_mem[h.addr] = h.wdata;
                m_rsp_valid   = WACK;
                if (WACK) m_rsp_rdata = '0;
            end else begin
                m_rsp_valid = 1'b1;
                m_rsp_rdata = m_mem[h.addr];
            end
        end
        if (acc) begin
            r.we = we; r.addr = a; r.wdata = wd;
            m_q.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_addr = '0;
        bus_if.req_wdata = '0;   bus_if.ld_valid = 1'b0; bus_if.ld_addr = '0;
        bus_if.ld_data = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus_if.req_ready); end
        n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", bus_if.rsp_rdata); end
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        rst = 1'b1;
        @(negedge clk);
        $display("reset: released");
    endtask

    task automatic test_host_load();
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 8'h10, 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 8'h10, '0, 1'b0, '0, '0);            // accepted in T
        n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL host_load_t1_valid: got %b want 0", bus_if.rsp_valid); end
        n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL host_load_t1_busy: got %b want 1", bus_if.busy); end
        idle();                                                  // now T+2
        n_checks++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL host_load_t2_valid: got %b want 1", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL host_load_t2_data: got %h want deadbeef", bus_if.rsp_rdata); end
        $display("host_load: rsp data=%h", bus_if.rsp_rdata);
        idle();
        n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL host_load_t3_valid: got %b want 0", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL host_load_hold: got %h want deadbeef", bus_if.rsp_rdata); end
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL host_load_idle_busy: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_read_after_write();
        cycle(1'b1, 1'b1, 8'h05, 32'h12345678, 1'b0, '0, '0);  // store at T
        cycle(1'b1, 1'b0, 8'h05, '0, 1'b0, '0, '0);             // load at T+1
        n_checks++; if (bus_if.rsp_valid !== WACK) begin n_fail++; $display("FAIL raw_t2_valid: got %b want %b", bus_if.rsp_valid, WACK); end
        n_checks++; if (bus_if.rsp_rdata !== m_rsp_rdata) begin n_fail++; $display("FAIL raw_t2_data: got %h want %h", bus_if.rsp_rdata, m_rsp_rdata); end
        idle();                                                  // T+3
        n_checks++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL raw_t3_valid: got %b want 1", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL raw_t3_data: got %h want 12345678", bus_if.rsp_rdata); end
        $display("raw: rsp data=%h", bus_if.rsp_rdata);
        idle();
        n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL raw_t4_valid: got %b want 0", bus_if.rsp_valid); end
    endtask

    task automatic test_backpressure();
        bit            exp_rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [AW-1:0] la;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus_if.req_ready !== exp_rdy[i]) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want %b", i, bus_if.req_ready, exp_rdy[i]); end
            la = 8'h40 + 8'(i);
            cycle(1'b1, 1'b0, (i == 0) ? 8'h10 : 8'h05, '0, 1'b1, la, 32'hCAFE0000 + 32'(i));
        end
        n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_stalled_valid: got %b want 0", bus_if.rsp_valid); end
        n_checks++; if (bus_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", bus_if.req_ready); end
        idle();
        n_checks++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp0_valid: got %b want 1", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_rsp0_data: got %h want deadbeef", bus_if.rsp_rdata); end
        n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_deq: got %b want 1", bus_if.req_ready); end
        $display("backpressure: rsp0 data=%h", bus_if.rsp_rdata);
        idle();
        n_checks++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp1_valid: got %b want 1", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL bp_rsp1_data: got %h want 12345678", bus_if.rsp_rdata); end
        $display("backpressure: rsp1 data=%h", bus_if.rsp_rdata);
        idle();
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL bp_drained_busy: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_streaming();
        bit exp_v;
        for (int a = 0; a < 8; a++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1, 8'(a), 32'h100 + 32'(a));
        end
        for (int i = 0; i < 10; i++) begin
            cycle(i < 8, 1'b0, 8'(i), '0, 1'b0, '0, '0);
            exp_v = (i >= 1) && (i <= 8);
            n_checks++; if (bus_if.rsp_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid_%0d: got %b want %b", i, bus_if.rsp_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (bus_if.rsp_rdata !== 32'h100 + 32'(i - 1)) begin n_fail++; $display("FAIL stream_data_%0d: got %h want %h", i, bus_if.rsp_rdata, 32'h100 + 32'(i - 1)); end
                $display("stream: rsp data=%h", bus_if.rsp_rdata);
            end
            n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_%0d: got %b want 1", i, bus_if.req_ready); end
        end
    endtask

    task automatic test_random();
        bit            v, we, ldv;
        logic [AW-1:0] a, la;
        for (int a0 = 8'h20; a0 < 8'h30; a0++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1, 8'(a0), $urandom);
        end
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            we  = $urandom_range(0, 1) == 1;
            ldv = ($urandom_range(0, 19) < 3);
            a   = 8'h20 + 8'($urandom_range(0, 15));
            la  = 8'h20 + 8'($urandom_range(0, 15));
            if (i >= 296) begin v = 1'b0; ldv = 1'b0; end
            cycle(v, we, a, $urandom, ldv, la, $urandom);
            n_checks++; if (bus_if.req_ready !== (m_q.size() < 2)) begin n_fail++; $display("FAIL rand_ready_%0d: got %b want %b", i, bus_if.req_ready, m_q.size() < 2); end
            n_checks++; if (bus_if.rsp_valid !== m_rsp_valid) begin n_fail++; $display("FAIL rand_valid_%0d: got %b want %b", i, bus_if.rsp_valid, m_rsp_valid); end
            n_checks++; if (bus_if.rsp_rdata !== m_rsp_rdata) begin n_fail++; $display("FAIL rand_data_%0d: got %h want %h", i, bus_if.rsp_rdata, m_rsp_rdata); end
            n_checks++; if (bus_if.busy !== ((m_q.size() != 0) || m_rsp_valid)) begin n_fail++; $display("FAIL rand_busy_%0d: got %b want %b", i, bus_if.busy, (m_q.size() != 0) || m_rsp_valid); end
        end
        $display("random: 300 cycles done");
    endtask

    task automatic test_mid_reset();
        cycle(1'b1, 1'b0, 8'h10, '0, 1'b1, 8'h80, 32'hA5A5A5A5);
        cycle(1'b1, 1'b0, 8'h05, '0, 1'b1, 8'h81, 32'h5A5A5A5A);
        n_checks++; if (bus_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_full_ready: got %b want 0", bus_if.req_ready); end
        bus_if.req_valid = 1'b0;
        bus_if.ld_valid  = 1'b0;
        rst = 1'b0;
        m_q.delete();
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus_if.busy); end
        n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", bus_if.req_ready); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp_%0d: got %b want 0", i, bus_if.rsp_valid); end
            idle();
        end
        cycle(1'b1, 1'b0, 8'h10, '0, 1'b0, '0, '0);
        idle();
        n_checks++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_after_valid: got %b want 1", bus_if.rsp_valid); end
        n_checks++; if (bus_if.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midrst_retained: got %h want deadbeef", bus_if.rsp_rdata); end
        $display("mid_reset: rsp data=%h", bus_if.rsp_rdata);
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_read_after_write();
        test_backpressure();
        test_streaming();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
